// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// Each bit is held PRESCALE clocks; words are accepted over a valid/ready handshake.
module uart_tx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE   = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_valid,
  input  logic                  i_par_en,
  input  logic                  i_par_typ,
  output logic                  o_ready,
  output logic                  o_busy,
  output logic                  o_tx
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    par_en_q, par_en_d;
  logic                    par_bit_q, par_bit_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    last_tick;
  logic [IW-1:0]           idx_nxt;

  assign last_tick = (cnt_q == PW'(PRESCALE - 1));
  assign idx_nxt   = idx_q + IW'(1);

  // State and datapath registers; reset drops the frame and returns the line high.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic; o_tx takes the next bit value on the edge that advances the state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    tx_d      = tx_q;
    busy_d    = busy_q;

    if (state_q != IDLE) begin
      cnt_d = last_tick ? '0 : cnt_q + PW'(1);
    end

    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        cnt_d  = '0;
        idx_d  = '0;
        if (i_data_valid) begin
          data_d    = i_data;
          par_en_d  = i_par_en;
          par_bit_d = (^i_data) ^ i_par_typ;
          state_d   = START;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      START: begin
        if (last_tick) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = data_q[0];
        end
      end
      DATA: begin
        if (last_tick) begin
          if (idx_q == IW'(DATA_WIDTH - 1)) begin
            idx_d = '0;
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_nxt;
            tx_d  = data_q[idx_nxt];
          end
        end
      end
      PARITY: begin
        if (last_tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (last_tick) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign o_ready = (state_q == IDLE);
  assign o_busy  = busy_q;
  assign o_tx    = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected frames, a line monitor decodes
// o_tx cycle by cycle and checks bits, hold time, busy/ready, inter-frame gap and reset abort.
module tb_uart_tx;

  localparam int unsigned DW = 8;
  localparam int unsigned P  = 4;

  logic          clk;
  logic          rst;
  logic [DW-1:0] data;
  logic          valid;
  logic          par_en;
  logic          par_typ;
  logic          ready;
  logic          busy;
  logic          tx;

  uart_tx #(.DATA_WIDTH(DW), .PRESCALE(P)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_data       (data),
    .i_data_valid (valid),
    .i_par_en     (par_en),
    .i_par_typ    (par_typ),
    .o_ready      (ready),
    .o_busy       (busy),
    .o_tx         (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         pe;
    bit         par;
    bit         abort;
    bit         chk_gap;
  } item_t;

  item_t q[$];
  int    n_total  = 0;
  int    n_passed = 0;
  int    frames_sent = 0;
  int    frames_seen = 0;

  // Monitor state
  bit    in_frame = 0;
  bit    post_pending = 0;
  bit    skip_frame = 0;
  int    cyc = 0;
  int    nbits = 0;
  int    gap = 0;
  int    bit_err = 0;
  int    hs_err = 0;
  item_t cur;
  logic  exp_bits [0:11];

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_total++;
    if (ok) n_passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Line monitor: samples on the falling edge, away from the active edge.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) begin
        if (in_frame) begin
          chk(cur.abort == 1'b1, "abort_expected", 1, int'(cur.abort));
          chk(bit_err == 0, "abort_bits_before_reset", bit_err, 0);
        end
        in_frame = 0; post_pending = 0; skip_frame = 0; gap = 0;
      end else if (skip_frame) begin
        if (!busy) skip_frame = 0;
      end else if (post_pending) begin
        chk(ready && !busy && tx, "post_frame_idle", int'({ready, busy, tx}), 3'b101);
        post_pending = 0;
        gap = 1;
      end else begin
        if (!in_frame) begin
          if (tx == 1'b0) begin
            frames_seen++;
            if (q.size() == 0) begin
              chk(1'b0, "unexpected_frame", frames_seen, frames_sent);
              skip_frame = 1;
            end else begin
              cur = q.pop_front();
              if (cur.chk_gap) chk(gap == 1, "interframe_gap", gap, 1);
              exp_bits[0] = 1'b0;
              for (int i = 0; i < 8; i++) exp_bits[i+1] = cur.data[i];
              if (cur.pe) begin
                exp_bits[9] = cur.par; exp_bits[10] = 1'b1; nbits = 11;
              end else begin
                exp_bits[9] = 1'b1; nbits = 10;
              end
              in_frame = 1; cyc = 0; bit_err = 0; hs_err = 0;
            end
          end else begin
            gap++;
          end
        end
        if (in_frame) begin
          if (tx !== exp_bits[cyc / P]) bit_err++;
          if (busy !== 1'b1 || ready !== 1'b0) hs_err++;
          cyc++;
          if (cyc == nbits * int'(P)) begin
            chk(bit_err == 0, $sformatf("frame_bits_%02h", cur.data), bit_err, 0);
            chk(hs_err == 0, $sformatf("busy_ready_%02h", cur.data), hs_err, 0);
            chk(cur.abort == 1'b0, "abort_missing", int'(cur.abort), 0);
            in_frame = 0;
            post_pending = 1;
          end
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk(1'b0, "ready_timeout", 0, 1);
  endtask

  task automatic push(input logic [7:0] d, input bit pe, input bit par,
                      input bit abort, input bit chk_gap);
    item_t it;
    it.data = d; it.pe = pe; it.par = par; it.abort = abort; it.chk_gap = chk_gap;
    q.push_back(it);
    frames_sent++;
  endtask

  task automatic send(input logic [7:0] d, input bit pe, input bit pt, input bit par,
                      input bit abort);
    wait_ready();
    data = d; par_en = pe; par_typ = pt; valid = 1'b1;
    push(d, pe, par, abort, 1'b0);
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    rst = 1'b1; data = '0; valid = 1'b0; par_en = 1'b0; par_typ = 1'b0;
    #3;
    chk(tx == 1'b1, "reset_tx", int'(tx), 1);
    chk(busy == 1'b0, "reset_busy", int'(busy), 0);
    chk(ready == 1'b1, "reset_ready", int'(ready), 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Hand-computed parities: 0xA5 has four ones, 0x07 three, 0x5A four.
    send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    send(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);

    // Inputs changed after accept must not affect the frame.
    send(8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
    data = 8'hFF; par_en = 1'b0; par_typ = 1'b1;

    // Back-to-back with valid held high.
    wait_ready();
    data = 8'h3C; par_en = 1'b0; par_typ = 1'b0; valid = 1'b1;
    push(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    data = 8'hC3;
    push(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_ready();
    @(posedge clk); #1;
    valid = 1'b0;

    // Valid pulsed while busy is ignored.
    send(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1 data = 8'h00; valid = 1'b1;
    @(posedge clk); #1 valid = 1'b0;

    // Reset during data bit 3 (cycles 16..19 after accept).
    send(8'h96, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (17) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk(tx == 1'b1, "midreset_tx", int'(tx), 1);
    chk(busy == 1'b0, "midreset_busy", int'(busy), 0);
    chk(ready == 1'b1, "midreset_ready", int'(ready), 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    send(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h5A, 1'b1, 1'b1, 1'b1, 1'b0);

    n = 0;
    while ((q.size() != 0 || in_frame || post_pending) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk(q.size() == 0 && !in_frame, "drain", q.size(), 0);
    repeat (30) @(posedge clk);
    chk(frames_seen == frames_sent, "frame_count", frames_seen, frames_sent);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter: serialises one parallel data word per frame onto a single line.
- Frame format: start bit, DATA_WIDTH data bits LSB first, optional even/odd parity bit, one stop bit.
- Sits at the TX end of the UART link and produces frames the UART_RX chain samples and checks (start, parity, stop).
- Upstream source hands words over with a valid/ready handshake. Bit timing is set by a fixed clock-cycles-per-bit prescale.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (5..9).
- PRESCALE, 8, clock cycles per serial bit (>=1).

Ports:
- i_clk  input  1  system clock, all logic on rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_data  input  DATA_WIDTH  word to transmit.
- i_data_valid  input  1  source presents a word this cycle.
- i_par_en  input  1  1 = append parity bit.
- i_par_typ  input  1  0 = even parity, 1 = odd parity.
- o_ready  output  1  transmitter can accept a word this cycle.
- o_busy  output  1  frame in progress.
- o_tx  output  1  serial line, idle high.

Behaviour:
- Reset (async, immediate): state=IDLE, o_tx=1, o_busy=0, o_ready=1, counters cleared. Reset mid-frame aborts the frame; the line returns high at once. No resume after reset.
- o_ready is a decode of state==IDLE. o_tx and o_busy are registered (glitch-free line).
- FSM states: IDLE -> START -> DATA -> (PARITY if latched par_en) -> STOP -> IDLE.
- Accept: at an edge where state==IDLE and i_data_valid=1, the block:
  - latches i_data, i_par_en and i_par_typ;
  - computes parity from the latched data: even = XOR of all bits, odd = ~XOR;
  - moves to START, sets o_tx=0 and o_busy=1 on that same edge.
- i_data_valid while not IDLE is ignored. Input changes after accept do not affect the frame in flight.
- Bit timing: a prescale counter counts 0..PRESCALE-1 and each bit is held exactly PRESCALE cycles. At terminal count the FSM advances and o_tx takes the next bit value on the same edge.
- DATA: a bit index runs 0..DATA_WIDTH-1 and o_tx = latched data[index], LSB first. After bit DATA_WIDTH-1 completes, go to PARITY if enabled, else STOP.
- PARITY: o_tx = computed parity bit, held PRESCALE cycles.
- STOP: o_tx=1 for PRESCALE cycles. At its terminal count go to IDLE and clear o_busy; o_tx stays 1.
- Frame length from the accept edge: (2 + DATA_WIDTH + par_en) * PRESCALE cycles.
- Back-to-back: with valid held high, the next accept occurs on the first IDLE cycle. The minimum inter-frame gap is 1 clock of idle-high beyond the stop bit.
- PRESCALE=1: each bit lasts one cycle and all transitions still apply; there is no zero-length state.
- Counters are sized ceil(log2(PRESCALE)) and ceil(log2(DATA_WIDTH)) with a minimum of 1 bit. They wrap to 0 on every bit or state advance.

Test Plan:
- PRESCALE=4, DATA_WIDTH=8, par_en=0, send 0xA5:
  - o_tx sequence 0,1,0,1,0,0,1,0,1,1, each held exactly 4 cycles.
  - o_busy high for 40 cycles; o_ready low throughout, high on cycle 41.
- par_en=1, send 0xA5:
  - even: parity bit=0; odd: parity bit=1.
  - Frame is 44 cycles; a UART_RX loopback reports no parity error and the stop bit checked.
- par_en=1, par_typ=0, send 0x07 -> parity bit=1. Change i_data to 0xFF mid-frame -> serialised bits remain 0x07.
- Hold i_data_valid=1 with two words 0x3C then 0xC3:
  - second start bit begins exactly 1 cycle after the first stop bit ends;
  - words 0x3C then 0xC3 are both sent intact.
- Pulse i_data_valid while o_busy=1 -> no effect: the frame is unchanged and no extra frame is sent.
- Assert i_rst during DATA bit 3 -> o_tx=1, o_busy=0 and o_ready=1 immediately (same cycle, before the clock edge). After release, sending 0x5A yields a clean, complete frame.
